// File: rtl/program_loader.sv
// Byte-stream boot loader: length-prefixed program packed into big-endian words and written to memory.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit checksum of the written words.
module program_loader #(
    parameter logic [31:0] base_addr = 32'h0,
    parameter int unsigned max_words = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wr_en,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, next_state;
    logic [1:0]  byte_cnt;
    logic [31:0] word;
    logic [31:0] len;
    logic [31:0] index;
    logic [31:0] index_next;
    logic [31:0] packed_word;
    logic        accept;
    logic        last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum;
`endif

    assign packed_word = {word[23:0], in_data};
    assign index_next  = index + 32'd1;
    assign accept      = in_valid && in_ready;
    assign last_byte   = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) state <= S_LEN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem_wr_en  = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_LEN: begin
                in_ready = 1'b1;
                if (last_byte) begin
                    if (packed_word == 32'd0)           next_state = S_DONE;
                    else if (packed_word > max_words)   next_state = S_ERROR;
                    else                                next_state = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (last_byte) next_state = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                if (index_next == len) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_DONE;
`endif
                end else begin
                    next_state = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                // sum already includes the last word: it is added on WRITE exit
                if (last_byte) next_state = (packed_word == sum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: next_state = S_LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            word     <= '0;
            len      <= '0;
            index    <= '0;
            mem_addr <= base_addr;
            mem_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            if (accept) begin
                word     <= packed_word;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == S_LEN && last_byte) len <= packed_word;
            if (state == S_DATA && last_byte) mem_data <= packed_word;
            if (state == S_WRITE) begin
                index    <= index_next;
                mem_addr <= mem_addr + 32'd4;
`ifdef LOADER_CHECKSUM_EN
                sum      <= sum + mem_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: hand-computed write addresses/data and status flags.
// Checksum scenario is built only when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wr_en;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] log_addr [0:31];
    logic [31:0] log_data [0:31];
    int unsigned wr_cnt = 0;
    int unsigned both_flags = 0;

    program_loader #(.base_addr(32'h0), .max_words(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wr_en (mem_wr_en),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) begin
            log_addr[wr_cnt[4:0]] <= mem_addr;
            log_data[wr_cnt[4:0]] <= mem_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(negedge clk) if (done && error) both_flags <= both_flags + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int unsigned n;
        if (gap) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_addr",   mem_addr,  32'h0);
        check("rst_data",   mem_data,  32'h0);
        check("rst_wr_en",  {31'd0, mem_wr_en}, 32'd0);
        check("rst_cpu",    {31'd0, cpu_reset}, 32'd1);
        check("rst_done",   {31'd0, done},      32'd0);
        check("rst_error",  {31'd0, error},     32'd0);
        check("rst_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int unsigned start;

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        apply_reset();

        // 1: N=2, gap-free
        start = wr_cnt;
        send_word(32'd2, 1'b0);
        send_word(32'h20080005, 1'b0);
        send_word(32'h2009000A, 1'b0);
        check("t1_wr_pulse", {31'd0, mem_wr_en}, 32'd1);
        check("t1_done_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("t1_done",  {31'd0, done},      32'd1);
        check("t1_cpu",   {31'd0, cpu_reset}, 32'd0);
        check("t1_ready", {31'd0, in_ready},  32'd0);
        check("t1_count", wr_cnt - start, 32'd2);
        check("t1_addr0", log_addr[start[4:0]],       32'h0);
        check("t1_data0", log_data[start[4:0]],       32'h20080005);
        check("t1_addr1", log_addr[start[4:0] + 5'd1], 32'h4);
        check("t1_data1", log_data[start[4:0] + 5'd1], 32'h2009000A);
        // bytes offered in DONE are ignored
        @(negedge clk); in_data = 8'h55; in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check("t1_sticky", {31'd0, done}, 32'd1);
        check("t1_no_more", wr_cnt - start, 32'd2);

        // 2: N=0
        apply_reset();
        start = wr_cnt;
        send_word(32'd0, 1'b0);
        check("t2_done",  {31'd0, done},      32'd1);
        check("t2_cpu",   {31'd0, cpu_reset}, 32'd0);
        repeat (3) @(posedge clk); #1;
        check("t2_count", wr_cnt - start, 32'd0);

        // 3: N=max_words+1
        apply_reset();
        start = wr_cnt;
        send_word(32'd1025, 1'b0);
        check("t3_error", {31'd0, error},     32'd1);
        check("t3_cpu",   {31'd0, cpu_reset}, 32'd1);
        check("t3_done",  {31'd0, done},      32'd0);
        check("t3_ready", {31'd0, in_ready},  32'd0);
        repeat (3) @(posedge clk); #1;
        check("t3_count", wr_cnt - start, 32'd0);

        // 4: N=3 with in_valid low every other cycle
        apply_reset();
        start = wr_cnt;
        send_word(32'd3, 1'b1);
        send_word(32'hA1B2C3D4, 1'b1);
        send_word(32'h00000001, 1'b1);
        send_word(32'hFFFFFFFF, 1'b1);
        repeat (2) @(posedge clk); #1;
        check("t4_done",  {31'd0, done}, 32'd1);
        check("t4_count", wr_cnt - start, 32'd3);
        check("t4_addr0", log_addr[start[4:0]],        32'h0);
        check("t4_data0", log_data[start[4:0]],        32'hA1B2C3D4);
        check("t4_addr1", log_addr[start[4:0] + 5'd1], 32'h4);
        check("t4_data1", log_data[start[4:0] + 5'd1], 32'h00000001);
        check("t4_addr2", log_addr[start[4:0] + 5'd2], 32'h8);
        check("t4_data2", log_data[start[4:0] + 5'd2], 32'hFFFFFFFF);

        // 5: reset mid-load after 6 bytes, then a fresh N=1 load
        apply_reset();
        send_word(32'd4, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        apply_reset();
        start = wr_cnt;
        send_word(32'd1, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        check("t5_done",  {31'd0, done}, 32'd1);
        check("t5_count", wr_cnt - start, 32'd1);
        check("t5_addr",  log_addr[start[4:0]], 32'h0);
        check("t5_data",  log_data[start[4:0]], 32'hDEADBEEF);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum good, then bad
        apply_reset();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        @(posedge clk); #1;
        check("t6_csum_wait", {31'd0, done}, 32'd0);
        send_word(32'd3, 1'b0);
        check("t6_good_done",  {31'd0, done},  32'd1);
        check("t6_good_error", {31'd0, error}, 32'd0);
        apply_reset();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        check("t6_bad_error", {31'd0, error},     32'd1);
        check("t6_bad_done",  {31'd0, done},      32'd0);
        check("t6_bad_cpu",   {31'd0, cpu_reset}, 32'd1);
`endif

        check("done_and_error", both_flags, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
